// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Turns instruction requests (kind + fields) into 32-bit MIPS words and writes
//   them to consecutive instruction-memory word addresses. The boot/self-test
//   path uses it to load a program before the pipeline is released.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_n_i          synchronous reset, active-low
//   start_i          opens a load session (only honoured while idle)
//   in_valid_i       request valid
//   in_ready_o       request accepted on in_valid_i & in_ready_o at posedge
//   in_kind_i        0=R 1=J 2=BEQ 3=LW 4=SW 5=ADDI 6=ANDI 7=illegal
//   in_rs_i/rt_i/rd_i, in_funct_i, in_imm_i, in_target_i   instruction fields
//   in_last_i        marks the final request of the session
//   imem_we_o        one-cycle write strobe
//   imem_addr_o      word address (held when no write)
//   imem_wdata_o     encoded instruction (held when no write)
//   busy_o           session in progress (not idle)
//   done_o           one-cycle pulse in the cycle the session ends
//   err_illegal_o    sticky: an illegal kind was seen this session
//   err_overflow_o   sticky: MAX_INSTR words written without in_last_i
//   wr_count_o       words written this session
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_INSTR = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_kind_i,
    input  logic [4:0]        in_rs_i,
    input  logic [4:0]        in_rt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [5:0]        in_funct_i,
    input  logic [15:0]       in_imm_i,
    input  logic [25:0]       in_target_i,
    input  logic              in_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_illegal_o,
    output logic              err_overflow_o,
    output logic [15:0]       wr_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
    localparam logic [15:0]       MAX_C  = 16'(MAX_INSTR);

    state_t              state_q;
    logic                ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   next_addr_q;   // address the next legal word goes to
    logic [31:0]         wdata_q;
    logic                done_q;
    logic                err_ill_q;
    logic                err_ovf_q;
    logic [15:0]         count_q;

    logic                accept;
    logic                legal;
    logic [15:0]         count_d;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (kind)
            3'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, funct};
            3'd1:    w = {6'b000010, target};
            3'd2:    w = {6'b000100, rs, rt, imm};
            3'd3:    w = {6'b100011, rs, rt, imm};
            3'd4:    w = {6'b101011, rs, rt, imm};
            3'd5:    w = {6'b001000, rs, rt, imm};
            3'd6:    w = {6'b001100, rs, rt, imm};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign accept  = in_valid_i & ready_q;
    assign legal   = (in_kind_i != 3'd7);
    // Count already includes the write issued by this accept, so ready can be
    // dropped in the same edge that fills the last slot.
    assign count_d = count_q + {15'd0, legal};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= BASE_C;
            next_addr_q <= BASE_C;
            wdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_ill_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_LOAD;
                        ready_q     <= 1'b1;
                        err_ill_q   <= 1'b0;
                        err_ovf_q   <= 1'b0;
                        count_q     <= 16'd0;
                        next_addr_q <= BASE_C;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            we_q        <= 1'b1;
                            addr_q      <= next_addr_q;
                            wdata_q     <= encode(in_kind_i, in_rs_i, in_rt_i, in_rd_i,
                                                  in_funct_i, in_imm_i, in_target_i);
                            next_addr_q <= next_addr_q + 1'b1;
                            count_q     <= count_d;
                        end else begin
                            err_ill_q <= 1'b1;
                        end
                        // The final write and the done pulse share the DONE cycle.
                        if (in_last_i || (count_d == MAX_C)) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                            if (!in_last_i) begin
                                err_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o     = ready_q;
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign err_illegal_o  = err_ill_q;
    assign err_overflow_o = err_ovf_q;
    assign wr_count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int MAX_INSTR = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_overflow;
    logic [15:0]       wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .MAX_INSTR(MAX_INSTR)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_kind_i     (in_kind),
        .in_rs_i       (in_rs),
        .in_rt_i       (in_rt),
        .in_rd_i       (in_rd),
        .in_funct_i    (in_funct),
        .in_imm_i      (in_imm),
        .in_target_i   (in_target),
        .in_last_i     (in_last),
        .imem_we_o     (imem_we),
        .imem_addr_o   (imem_addr),
        .imem_wdata_o  (imem_wdata),
        .busy_o        (busy),
        .done_o        (done),
        .err_illegal_o (err_illegal),
        .err_overflow_o(err_overflow),
        .wr_count_o    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mdl_enc(input int kind, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] rd,
                                            input logic [31:0] funct, input logic [31:0] imm,
                                            input logic [31:0] target);
        logic [31:0] op;
        case (kind)
            2: op = 32'd4;
            3: op = 32'd35;
            4: op = 32'd43;
            5: op = 32'd8;
            6: op = 32'd12;
            default: op = 32'd0;
        endcase
        if (kind == 0) return (rs << 21) + (rt << 16) + (rd << 11) + funct;
        if (kind == 1) return (32'd2 << 26) + target;
        return (op << 26) + (rs << 21) + (rt << 16) + imm;
    endfunction

    bit          mdl_ok = 0;
    bit          m_open = 0;     // session accepting requests
    bit          m_ending = 0;   // session just closed, one cycle until idle
    int          m_next_addr;
    int          m_words;
    logic        e_we, e_done, e_busy, e_ready, e_eill, e_eovf;
    logic [31:0] e_addr, e_wdata;

    always @(posedge clk) begin
        e_we   = 1'b0;
        e_done = 1'b0;
        if (!rst_n) begin
            mdl_ok = 1; m_open = 0; m_ending = 0;
            m_words = 0; m_next_addr = BASE_ADDR;
            e_busy = 0; e_ready = 0; e_eill = 0; e_eovf = 0;
            e_addr = BASE_ADDR; e_wdata = 0;
        end else if (m_ending) begin
            m_ending = 0;
            e_busy   = 0;
        end else if (!m_open) begin
            if (start) begin
                m_open = 1; e_busy = 1; e_ready = 1;
                e_eill = 0; e_eovf = 0;
                m_words = 0; m_next_addr = BASE_ADDR;
            end
        end else if (in_valid && e_ready) begin
            if (in_kind != 3'd7) begin
                e_we    = 1'b1;
                e_addr  = m_next_addr;
                e_wdata = mdl_enc(int'(in_kind), in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
                m_next_addr = (m_next_addr + 1) % (1 << ADDR_W);
                m_words++;
            end else begin
                e_eill = 1'b1;
            end
            if (in_last || m_words == MAX_INSTR) begin
                if (!in_last) e_eovf = 1'b1;
                m_open = 0; m_ending = 1; e_done = 1'b1; e_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("ready",    {31'd0, in_ready},     {31'd0, e_ready});
            chk("we",       {31'd0, imem_we},      {31'd0, e_we});
            chk("addr",     32'(imem_addr),        e_addr);
            chk("wdata",    imem_wdata,            e_wdata);
            chk("busy",     {31'd0, busy},         {31'd0, e_busy});
            chk("done",     {31'd0, done},         {31'd0, e_done});
            chk("err_ill",  {31'd0, err_illegal},  {31'd0, e_eill});
            chk("err_ovf",  {31'd0, err_overflow}, {31'd0, e_eovf});
            chk("wr_count", 32'(wr_count),         32'(m_words));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int funct, input int imm, input int target, input bit last);
        in_valid  = 1'b1;
        in_kind   = 3'(kind);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_funct  = 6'(funct);
        in_imm    = 16'(imm);
        in_target = 26'(target);
        in_last   = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 0; start = 0; in_valid = 0; in_kind = 0; in_rs = 0; in_rt = 0;
        in_rd = 0; in_funct = 0; in_imm = 0; in_target = 0; in_last = 0;
        repeat (2) @(negedge clk);
        chk("rst_we",    {31'd0, imem_we}, 32'd0);
        chk("rst_busy",  {31'd0, busy},    32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_addr",  32'(imem_addr),   32'd0);
        chk("rst_wdata", imem_wdata,       32'd0);
        chk("rst_cnt",   32'(wr_count),    32'd0);
        rst_n = 1;
        @(negedge clk);

        // single R-type with last
        do_start();
        send(0, 1, 2, 3, 'h20, 0, 0, 1);
        chk("t1_we",    {31'd0, imem_we}, 32'd1);
        chk("t1_addr",  32'(imem_addr),   32'd0);
        chk("t1_wdata", imem_wdata,       32'h00221820);
        chk("t1_done",  {31'd0, done},    32'd1);
        chk("t1_cnt",   32'(wr_count),    32'd1);
        @(negedge clk);
        chk("t1_idle",  {31'd0, busy},    32'd0);

        // LW then SW back-to-back
        do_start();
        send(3, 4, 5, 0, 0, 'h0010, 0, 0);
        chk("t2_lw_data", imem_wdata, 32'h8C850010);
        chk("t2_lw_addr", 32'(imem_addr), 32'd0);
        send(4, 4, 5, 0, 0, 'h0010, 0, 1);
        chk("t2_sw_data", imem_wdata, 32'hAC850010);
        chk("t2_sw_addr", 32'(imem_addr), 32'd1);
        chk("t2_done",    {31'd0, done}, 32'd1);
        @(negedge clk);

        // J then BEQ
        do_start();
        send(1, 0, 0, 0, 0, 0, 'h0000040, 0);
        chk("t3_j",   imem_wdata, 32'h08000040);
        send(2, 1, 2, 0, 0, 'hFFFF, 0, 1);
        chk("t3_beq", imem_wdata, 32'h1022FFFF);
        @(negedge clk);

        // illegal between two ADDI
        do_start();
        send(5, 0, 1, 0, 0, 5, 0, 0);
        chk("t4_a0_data", imem_wdata, 32'h20010005);
        chk("t4_a0_addr", 32'(imem_addr), 32'd0);
        send(7, 9, 9, 9, 9, 9, 9, 0);
        chk("t4_ill_we",  {31'd0, imem_we}, 32'd0);
        chk("t4_ill_err", {31'd0, err_illegal}, 32'd1);
        send(5, 0, 1, 0, 0, 5, 0, 1);
        chk("t4_a1_data", imem_wdata, 32'h20010005);
        chk("t4_a1_addr", 32'(imem_addr), 32'd1);
        chk("t4_cnt",     32'(wr_count), 32'd2);
        @(negedge clk);

        // overflow: six ANDI, no last, capacity four
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(6, 2, 3, 0, 0, 'h00FF, 0, 0);
            chk("t5_data", imem_wdata, 32'h304300FF);
            chk("t5_addr", 32'(imem_addr), 32'(i));
        end
        chk("t5_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_ovf",   {31'd0, err_overflow}, 32'd1);
        chk("t5_done",  {31'd0, done}, 32'd1);
        in_valid = 1; in_kind = 3'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_extra_we", {31'd0, imem_we}, 32'd0);
        end
        in_valid = 0;
        chk("t5_ovf_sticky", {31'd0, err_overflow}, 32'd1);
        @(negedge clk);

        // reset mid-session drops the pending write
        do_start();
        send(5, 0, 1, 0, 0, 5, 0, 0);
        in_valid = 1; in_kind = 3'd5; rst_n = 0;
        @(negedge clk);
        in_valid = 0; rst_n = 1;
        chk("t6_we",   {31'd0, imem_we}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cnt",  32'(wr_count), 32'd0);
        // start while busy is ignored
        do_start();
        send(5, 0, 1, 0, 0, 5, 0, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t6_cnt_kept", 32'(wr_count), 32'd1);
        send(5, 0, 1, 0, 0, 5, 0, 1);
        chk("t6_addr", 32'(imem_addr), 32'd1);
        chk("t6_cnt2", 32'(wr_count), 32'd2);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
